div_unit: RTL and testbench

Iterative 32-bit integer divider serving `div.w[u]` / `mod.w[u]` for the dual-issue pipeline. It accepts one operation per start pulse from EX1 and computes one quotient bit per cycle. It returns quotient and remainder with a one-cycle `div_ready` pulse, which the EX2/WB stage selects according to the uop. While busy it asserts `stall_divider` so the front of the pipeline holds.

---
 rtl/div_unit_pkg.sv | 36 +++
 rtl/div_unit.sv | 132 +++++++++++++
 tb/tb_div_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative integer divider: state encoding,
// iteration count and sign-handling helpers.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_ITER  = 32;
    localparam logic [4:0]  DIV_LAST  = 5'd31;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    // Magnitude of a value, interpreting it as two's complement only when en=1.
    function automatic logic [DIV_WIDTH-1:0] abs_if(input logic [DIV_WIDTH-1:0] v,
                                                    input logic                 en);
        if (en && v[DIV_WIDTH-1]) begin
            return {DIV_WIDTH{1'b0}} - v;
        end else begin
            return v;
        end
    endfunction

    // Conditional two's-complement negation.
    function automatic logic [DIV_WIDTH-1:0] neg_if(input logic [DIV_WIDTH-1:0] v,
                                                    input logic                 en);
        if (en) begin
            return {DIV_WIDTH{1'b0}} - v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider, one quotient bit per cycle. Signed operation
// divides magnitudes and fixes the signs afterwards; divide-by-zero returns
// all-ones / dividend with the same fixed latency as any other operation.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_ready,
    output logic             stall_divider
);

    div_state_e       state_r;
    logic [4:0]       cnt_r;
    // The partial remainder always ends a step below b, so 32 bits hold it;
    // only the shifted value needs the extra 33rd bit.
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] dd_raw_r;
    logic             q_neg_r;
    logic             r_neg_r;
    logic             div0_r;

    logic             start_accept_s;
    logic [WIDTH:0]   p_shift_s;
    logic [WIDTH:0]   p_diff_s;
    logic             p_ge_s;
    logic [WIDTH-1:0] p_next_s;
    logic [WIDTH-1:0] a_next_s;

    // A start counts only when the unit can take it and no flush kills it.
    always_comb begin
        start_accept_s = 1'b0;
        if (start && !flush && (state_r == DIV_IDLE || state_r == DIV_DONE)) begin
            start_accept_s = 1'b1;
        end else begin
            start_accept_s = 1'b0;
        end
    end

    assign stall_divider = start_accept_s || (state_r == DIV_CALC) || (state_r == DIV_FIX);

    // One restoring step: shift {P,A} left, subtract b when it fits.
    always_comb begin
        p_shift_s = {p_r, a_r[WIDTH-1]};
        p_diff_s  = p_shift_s - {1'b0, b_r};
        p_ge_s    = (p_shift_s >= {1'b0, b_r});
        p_next_s  = p_shift_s[WIDTH-1:0];
        a_next_s  = {a_r[WIDTH-2:0], p_ge_s};
        if (p_ge_s) begin
            p_next_s = p_diff_s[WIDTH-1:0];
        end else begin
            p_next_s = p_shift_s[WIDTH-1:0];
        end
    end

    // Control FSM with datapath registers and registered results.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r   <= DIV_IDLE;
            cnt_r     <= 5'd0;
            p_r       <= {WIDTH{1'b0}};
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            dd_raw_r  <= {WIDTH{1'b0}};
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            div0_r    <= 1'b0;
            quotient  <= {WIDTH{1'b0}};
            remainder <= {WIDTH{1'b0}};
            div_ready <= 1'b0;
        end else if (flush) begin
            state_r   <= DIV_IDLE;
            div_ready <= 1'b0;
        end else begin
            case (state_r)
                DIV_IDLE, DIV_DONE: begin
                    div_ready <= 1'b0;
                    if (start_accept_s) begin
                        a_r      <= abs_if(dividend, is_signed);
                        b_r      <= abs_if(divisor, is_signed);
                        q_neg_r  <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_r  <= is_signed & dividend[WIDTH-1];
                        div0_r   <= (divisor == {WIDTH{1'b0}});
                        dd_raw_r <= dividend;
                        p_r      <= {WIDTH{1'b0}};
                        cnt_r    <= 5'd0;
                        state_r  <= DIV_CALC;
                    end else begin
                        state_r  <= DIV_IDLE;
                    end
                end
                DIV_CALC: begin
                    p_r   <= p_next_s;
                    a_r   <= a_next_s;
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == DIV_LAST) begin
                        state_r <= DIV_FIX;
                    end else begin
                        state_r <= DIV_CALC;
                    end
                end
                DIV_FIX: begin
                    if (div0_r) begin
                        quotient  <= {WIDTH{1'b1}};
                        remainder <= dd_raw_r;
                    end else begin
                        quotient  <= neg_if(a_r, q_neg_r);
                        remainder <= neg_if(p_r, r_neg_r);
                    end
                    div_ready <= 1'b1;
                    state_r   <= DIV_DONE;
                end
                default: begin
                    div_ready <= 1'b0;
                    state_r   <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, random operands
// against an arithmetic reference, and hand-written flush/reset sequences.
module tb_div_unit;

    logic        clk;
    logic        aresetn;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_ready;
    logic        stall_divider;

    int checks;
    int failures;
    logic [31:0] last_q;
    logic [31:0] last_r;

    typedef struct {
        logic [31:0] dd;
        logic [31:0] dv;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[10];

    div_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .start         (start),
        .is_signed     (is_signed),
        .dividend      (dividend),
        .divisor       (divisor),
        .flush         (flush),
        .quotient      (quotient),
        .remainder     (remainder),
        .div_ready     (div_ready),
        .stall_divider (stall_divider)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    function automatic void ref_div(input logic [31:0] dd, input logic [31:0] dv,
                                    input logic sgn,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, qq, rr;
        if (dv == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = dd;
        end else if (sgn) begin
            sa = $signed(dd);
            sb = $signed(dv);
            qq = sa / sb;
            rr = sa % sb;
            q = qq[31:0];
            r = rr[31:0];
        end else begin
            sa = {32'd0, dd};
            sb = {32'd0, dv};
            qq = sa / sb;
            rr = sa % sb;
            q = qq[31:0];
            r = rr[31:0];
        end
    endfunction

    // Issue one op at the current negedge; return at the negedge of its result cycle.
    task automatic run_op(input string name, input logic [31:0] dd, input logic [31:0] dv,
                          input logic sgn, input logic [31:0] eq, input logic [31:0] er);
        dividend  = dd;
        divisor   = dv;
        is_signed = sgn;
        start     = 1'b1;
        #1;
        check($sformatf("%s stall c0", name), {31'd0, stall_divider}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            check($sformatf("%s stall c%0d", name, c), {31'd0, stall_divider},
                  (c <= 33) ? 32'd1 : 32'd0);
            check($sformatf("%s ready c%0d", name, c), {31'd0, div_ready},
                  (c == 34) ? 32'd1 : 32'd0);
        end
        check($sformatf("%s quotient", name), quotient, eq);
        check($sformatf("%s remainder", name), remainder, er);
        last_q = eq;
        last_r = er;
    endtask

    // Idle for n cycles expecting no result pulse and no stall.
    task automatic expect_quiet(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check($sformatf("%s ready", name), {31'd0, div_ready}, 32'd0);
            check($sformatf("%s stall", name), {31'd0, stall_divider}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rdd, rdv, eq, er;
        logic        rs;
        checks    = 0;
        failures  = 0;
        last_q    = 32'd0;
        last_r    = 32'd0;
        aresetn   = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        flush     = 1'b0;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
        vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};
        vecs[4] = '{32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5};
        vecs[5] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5};
        vecs[6] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
        vecs[7] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
        vecs[8] = '{32'd0,          32'd1,          1'b1, 32'd0,          32'd0};
        vecs[9] = '{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset ready", {31'd0, div_ready}, 32'd0);
        check("reset stall", {31'd0, stall_divider}, 32'd0);
        aresetn = 1'b1;
        @(negedge clk);

        // Directed table; each op starts in the previous op's DONE cycle (back-to-back).
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv, vecs[i].sgn,
                   vecs[i].q, vecs[i].r);
        end
        expect_quiet("idle after table", 2);

        // Random operands against the reference.
        for (int i = 0; i < 40; i++) begin
            rdd = $urandom;
            rs  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rdv = 32'd0;
                1: rdv = 32'hFFFF_FFFF;
                2: rdv = 32'($urandom_range(1, 15));
                3: rdv = 32'h8000_0000;
                4: rdv = $urandom >> $urandom_range(0, 31);
                default: rdv = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) rdd = 32'h8000_0000;
            ref_div(rdd, rdv, rs, eq, er);
            run_op($sformatf("rnd%0d", i), rdd, rdv, rs, eq, er);
        end
        @(negedge clk);

        // Flush at N+10, then a new start at N+12.
        dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check("flush pre ready", {31'd0, div_ready}, 32'd0);
            check("flush pre stall", {31'd0, stall_divider}, 32'd1);
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush c11 stall", {31'd0, stall_divider}, 32'd0);
        check("flush c11 ready", {31'd0, div_ready}, 32'd0);
        check("flush keeps quotient", quotient, last_q);
        check("flush keeps remainder", remainder, last_r);
        @(negedge clk);
        run_op("after flush", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1);
        expect_quiet("idle after flush op", 1);

        // Flush wins over start in the same cycle.
        dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
        #1;
        check("flush+start stall", {31'd0, stall_divider}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        expect_quiet("dropped start", 36);
        check("dropped keeps quotient", quotient, last_q);

        // Asynchronous reset mid-CALC.
        dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 9; c++) @(negedge clk);
        aresetn = 1'b0;
        #1;
        check("midreset quotient", quotient, 32'd0);
        check("midreset remainder", remainder, 32'd0);
        check("midreset ready", {31'd0, div_ready}, 32'd0);
        check("midreset stall", {31'd0, stall_divider}, 32'd0);
        start = 1'b1;
        #1;
        check("reset stall follows start", {31'd0, stall_divider}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        expect_quiet("after reset", 36);
        run_op("post reset", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
